// File: rtl/muldiv_ctrl_if.sv
// Bus bundle between the EX stage, the HI/LO file, the external multiplier /
// divider datapaths and the multiply/divide controller.
//
// Ports (all logic):
//   flush, stall_ex, op_valid, op[1:0], src1[31:0], src2[31:0]   pipeline -> ctrl
//   stallreq, busy                                               ctrl -> pipeline
//   div_start, div_signed, div_annul, div_opdata1/2[31:0]        ctrl -> divider
//   div_ready, div_result[63:0] ({rem, quot})                    divider -> ctrl
//   mul_signed, mul_ina/inb[31:0]                                ctrl -> multiplier
//   mul_result[63:0]                                             multiplier -> ctrl
//   hilo_we, hi_wdata/lo_wdata[31:0]                             ctrl -> HI/LO
// The controller uses the slave modport; the surrounding environment uses master.
interface muldiv_ctrl_if;
  logic        flush;
  logic        stall_ex;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stallreq;
  logic        busy;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_ready;
  logic [63:0] div_result;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  modport slave (
    input  flush, stall_ex, op_valid, op, src1, src2,
    input  div_ready, div_result, mul_result,
    output stallreq, busy,
    output div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    output mul_signed, mul_ina, mul_inb,
    output hilo_we, hi_wdata, lo_wdata
  );

  modport master (
    output flush, stall_ex, op_valid, op, src1, src2,
    output div_ready, div_result, mul_result,
    input  stallreq, busy,
    input  div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    input  mul_signed, mul_ina, mul_inb,
    input  hilo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller for the EX stage.
// Accepts a mult/multu/div/divu from IDLE, drives an external divider
// (handshake on div_ready) or a fixed-latency multiplier (MUL_LAT cycles),
// captures the 64-bit result and writes it to HI/LO with a single hilo_we
// pulse once the downstream stage is not stalled.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - muldiv_ctrl_if.slave, see interface header for signal list
//
// All outputs are decoded from registered state and latched operands; only
// stallreq (IDLE accept), div_start/div_annul (flush) and hilo_we (stall_ex,
// flush) look at live inputs because they must react in the same cycle.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT     = 2,
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    MUL_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Counter reload: MUL_WAIT lasts MUL_LAT cycles, capturing on the last one.
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 32'd1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [1:0]  op_q,    op_d;
  logic [31:0] src1_q,  src1_d;
  logic [31:0] src2_q,  src2_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  logic in_idle_s;
  logic in_div_s;
  logic in_mul_s;
  logic in_done_s;

  // Next-state and datapath capture logic; flush overrides every other event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.op_valid) begin
            op_d   = bus.op;
            src1_d = bus.src1;
            src2_d = bus.src2;
            if (bus.op[1]) begin
              if (bus.src2 == 32'd0) begin
                // Divide-by-zero never touches the divider.
                state_d = DONE;
                hi_d    = bus.src1;
                lo_d    = DIV_ZERO_LO;
              end else begin
                state_d = DIV_BUSY;
              end
            end else begin
              state_d = MUL_WAIT;
              cnt_d   = CNT_INIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DIV_BUSY: begin
          if (bus.div_ready) begin
            state_d = DONE;
            hi_d    = bus.div_result[63:32];
            lo_d    = bus.div_result[31:0];
          end else begin
            state_d = DIV_BUSY;
          end
        end
        MUL_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = DONE;
            hi_d    = bus.mul_result[63:32];
            lo_d    = bus.mul_result[31:0];
          end else begin
            state_d = MUL_WAIT;
            cnt_d   = cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (!bus.stall_ex) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter, operand and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      src1_q  <= 32'd0;
      src2_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign in_idle_s = (state_q == IDLE);
  assign in_div_s  = (state_q == DIV_BUSY);
  assign in_mul_s  = (state_q == MUL_WAIT);
  assign in_done_s = (state_q == DONE);

  // stallreq is gated by rst so a held op_valid cannot leak out during reset.
  assign bus.stallreq    = !rst & ((in_idle_s & bus.op_valid & !bus.flush) | in_div_s | in_mul_s);
  assign bus.busy        = !in_idle_s;

  assign bus.div_start   = in_div_s & !bus.flush;
  assign bus.div_annul   = in_div_s & bus.flush;
  assign bus.div_signed  = in_div_s & ~op_q[0];
  assign bus.div_opdata1 = in_div_s ? src1_q : 32'd0;
  assign bus.div_opdata2 = in_div_s ? src2_q : 32'd0;

  assign bus.mul_signed  = in_mul_s & ~op_q[0];
  assign bus.mul_ina     = in_mul_s ? src1_q : 32'd0;
  assign bus.mul_inb     = in_mul_s ? src2_q : 32'd0;

  // Exactly one write: DONE is left on the same edge that hilo_we is seen.
  assign bus.hilo_we     = in_done_s & !bus.stall_ex & !bus.flush;
  assign bus.hi_wdata    = in_done_s ? hi_q : 32'd0;
  assign bus.lo_wdata    = in_done_s ? lo_q : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural multiplier (MUL_LAT-cycle
// pipeline) and divider (programmable latency, junk result when not ready),
// directed scenarios plus randomized operations against an arithmetic model.
module tb_muldiv_ctrl;
  localparam int unsigned MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   div_lat = 1;
  int   div_cnt = 0;
  logic [63:0] mul_pipe = 64'd0;
  logic [63:0] junk = 64'd0;

  always #5 clk = ~clk;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ZERO_LO(32'hFFFF_FFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Multiplier: result appears MUL_LAT-1 edges after operands are presented.
  always @(posedge clk) mul_pipe <= mul_model(bus.mul_ina, bus.mul_inb, bus.mul_signed);
  assign bus.mul_result = mul_pipe;

  // Divider: ready in the div_lat-th consecutive cycle of div_start.
  always @(posedge clk) begin
    if (bus.div_start) div_cnt <= div_cnt + 1;
    else               div_cnt <= 0;
    junk <= {$urandom, $urandom};
  end
  assign bus.div_ready  = bus.div_start && (div_cnt == div_lat - 1);
  assign bus.div_result = bus.div_ready ? div_model(bus.div_opdata1, bus.div_opdata2, bus.div_signed) : junk;

  // Reference HI/LO from the instruction semantics.
  function automatic logic [63:0] ref_hilo(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    int              q, r;
    logic [63:0]     res;
    case (o)
      2'b00: begin p = longint'(int'(a)) * longint'(int'(b)); res = p; end
      2'b01: begin pu = 64'(a) * 64'(b); res = pu; end
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin q = int'(a) / int'(b); r = int'(a) % int'(b); res = {r, q}; end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation, hold stall_ex for stall_n DONE cycles, check result,
  // stall length, DONE residency, divider activity and return to IDLE.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int dlat, input int stall_n, input string tag, output logic [63:0] got);
    logic [63:0] exp_v;
    int  exp_sr, sr_cnt, we_cnt, done_cyc, ds_cnt;
    bit  fin, in_done;
    exp_v = ref_hilo(o, a, b);
    exp_sr = o[1] ? ((b == 32'd0) ? 1 : 1 + dlat) : 1 + int'(MUL_LAT);
    sr_cnt = 0; we_cnt = 0; done_cyc = 0; ds_cnt = 0; fin = 1'b0; got = 64'd0;
    @(negedge clk);
    div_lat = dlat;
    bus.op_valid = 1'b1; bus.op = o; bus.src1 = a; bus.src2 = b; bus.stall_ex = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (c > 0) begin
        @(negedge clk);
        bus.op_valid = 1'b0;
      end
      #1;
      in_done = bus.busy && !bus.stallreq;
      bus.stall_ex = in_done && (done_cyc < stall_n);
      #1;
      if (bus.stallreq) sr_cnt++;
      if (bus.div_start) ds_cnt++;
      if (in_done) done_cyc++;
      if (bus.hilo_we) begin
        we_cnt++;
        got = {bus.hi_wdata, bus.lo_wdata};
        fin = 1'b1;
      end
    end
    check({tag, ".done"}, 64'(fin), 64'd1);
    check({tag, ".hilo"}, got, exp_v);
    check({tag, ".stallreq_cycles"}, 64'(sr_cnt), 64'(exp_sr));
    check({tag, ".done_cycles"}, 64'(done_cyc), 64'(stall_n + 1));
    check({tag, ".div_start_cycles"}, 64'(ds_cnt), 64'((o[1] && b != 32'd0) ? dlat : 0));
    @(negedge clk);
    bus.stall_ex = 1'b0;
    #1;
    check({tag, ".idle_after"}, 64'({bus.busy, bus.stallreq, bus.hilo_we, bus.hi_wdata}), 64'd0);
  endtask

  initial begin
    logic [63:0] got;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          cnt_we, cnt_busy;

    rst = 1'b1;
    bus.flush = 1'b0; bus.stall_ex = 1'b0; bus.op_valid = 1'b1; bus.op = 2'b10;
    bus.src1 = 32'd9; bus.src2 = 32'd3;
    #12;
    // Outputs must be quiet in reset even with op_valid held high.
    check("reset.ctrl", 64'({bus.stallreq, bus.busy, bus.div_start, bus.div_annul, bus.div_signed,
                             bus.mul_signed, bus.hilo_we}), 64'd0);
    check("reset.data", {bus.div_opdata1, bus.mul_ina}, 64'd0);
    bus.op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset", 64'({bus.stallreq, bus.busy, bus.hilo_we, bus.hi_wdata}), 64'd0);

    // Signed divide, 33-cycle divider.
    do_op(2'b10, 32'd100, 32'd7, 33, 0, "div_100_7", got);
    check("div_100_7.const", got, {32'd2, 32'd14});

    // Signed multiply with negative operand.
    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0, "mult_neg", got);
    check("mult_neg.const", got, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    // Divide-by-zero.
    do_op(2'b11, 32'd5, 32'd0, 1, 0, "divu_zero", got);
    check("divu_zero.const", got, {32'd5, 32'hFFFF_FFFF});

    // Unsigned multiply with three stalled DONE cycles.
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 3, "multu_stall", got);
    check("multu_stall.const", got, {32'd1, 32'hFFFF_FFFE});

    // Signed divide with negative dividend: truncation toward zero.
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5, 1, "div_neg", got);
    check("div_neg.const", got, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Flush during DIV_BUSY at cycle 10.
    @(negedge clk);
    div_lat = 33;
    bus.op_valid = 1'b1; bus.op = 2'b10; bus.src1 = 32'd1000; bus.src2 = 32'd3;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("flush.pre", {31'd0, bus.div_start, bus.div_signed, bus.div_opdata1}, {31'd0, 1'b1, 1'b1, 32'd1000});
    bus.flush = 1'b1;
    #1;
    check("flush.annul", 64'({bus.div_annul, bus.div_start, bus.hilo_we}), 64'b100);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush.after", 64'({bus.busy, bus.stallreq, bus.div_annul, bus.div_start}), 64'd0);
    cnt_we = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus.hilo_we) cnt_we++;
    end
    check("flush.no_we", 64'(cnt_we), 64'd0);

    // Flush in DONE beats stall_ex and suppresses the write.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 2'b01; bus.src1 = 32'd6; bus.src2 = 32'd7;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("flush_done.in_done", 64'({bus.busy, bus.stallreq, bus.hi_wdata, bus.lo_wdata}), {2'b10, 32'd0, 32'd42});
    bus.flush = 1'b1; bus.stall_ex = 1'b1;
    #1;
    check("flush_done.we", 64'(bus.hilo_we), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0; bus.stall_ex = 1'b0;
    #1;
    check("flush_done.idle", 64'({bus.busy, bus.hilo_we}), 64'd0);

    // Asynchronous reset in the middle of DIV_BUSY.
    @(negedge clk);
    div_lat = 33;
    bus.op_valid = 1'b1; bus.op = 2'b11; bus.src1 = 32'd50; bus.src2 = 32'd5;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rst_mid.busy", 64'({bus.busy, bus.div_start}), 64'b11);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.outputs", 64'({bus.busy, bus.stallreq, bus.div_start, bus.hilo_we, bus.div_opdata1}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_we = 0; cnt_busy = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus.hilo_we) cnt_we++;
      if (bus.busy) cnt_busy++;
    end
    check("rst_mid.no_we", 64'(cnt_we), 64'd0);
    check("rst_mid.no_busy", 64'(cnt_busy), 64'd0);

    // Randomized operations.
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) rb = 32'd0;
      if (ro == 2'b10 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd7;
      do_op(ro, ra, rb, int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), $sformatf("rand%0d", i), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
